// File: rtl/macc_pkg.sv
// Shared types and defaults for the output-stationary MAC grid and its feeder.
package macc_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIM        = 4;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    HOLD
  } feeder_state_t;

  // Element k of a packed row at the default sizes.
  function automatic logic [DEF_DATA_WIDTH-1:0] elem(
    input logic [DEF_DIM*DEF_DATA_WIDTH-1:0] vec,
    input int                                k
  );
    return vec[k*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/feeder_lane.sv
// One buffered row (A) or column (B) plus its registered skewed output lane.
module feeder_lane
  import macc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM,
  parameter int STEP_W     = $clog2(3*DEF_DIM-1),
  parameter int LANE       = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIM-1:0]            wr_mask,
  input  logic [DIM*DATA_WIDTH-1:0] wr_vec,
  input  logic                      feed_next,
  input  logic [STEP_W-1:0]         step_next,
  output logic [DATA_WIDTH-1:0]     lane_out
);

  localparam int IDX_W = $clog2(3*DIM) + 1;
  localparam logic signed [IDX_W-1:0] DIM_S  = IDX_W'(DIM);
  localparam logic signed [IDX_W-1:0] LANE_S = IDX_W'(LANE);

  logic [DIM*DATA_WIDTH-1:0] buf_reg;
  logic [DIM*DATA_WIDTH-1:0] buf_next;
  logic signed [IDX_W-1:0]   idx;
  logic                      in_range;
  logic [DATA_WIDTH-1:0]     sel;

  // Selection looks through a same-cycle write so write+go uses the new data.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_elem
      assign buf_next[gi*DATA_WIDTH +: DATA_WIDTH] = wr_mask[gi] ?
             wr_vec[gi*DATA_WIDTH +: DATA_WIDTH] : buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign idx      = $signed(IDX_W'(step_next)) - LANE_S;
  assign in_range = feed_next && !idx[IDX_W-1] && (idx < DIM_S);

  always_comb begin
    sel = '0;
    for (int m = 0; m < DIM; m++) begin
      if (idx == IDX_W'(m)) sel = buf_next[m*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg  <= '0;
      lane_out <= '0;
    end else begin
      buf_reg  <= buf_next;
      lane_out <= in_range ? sel : '0;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers A and B, streams skewed diagonals into the MAC grid, then holds and flags results.
module systolic_feeder
  import macc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic                      wr_sel_i,
  input  logic [$clog2(DIM)-1:0]    wr_row_i,
  input  logic [DIM*DATA_WIDTH-1:0] wr_data_i,
  input  logic                      go_i,
  input  logic                      res_ack_i,
  output logic [DIM*DATA_WIDTH-1:0] a_row_o,
  output logic [DIM*DATA_WIDTH-1:0] b_col_o,
  output logic                      start_bit_o,
  output logic                      busy_o,
  output logic                      results_valid_o
);

  localparam int ROW_W  = $clog2(DIM);
  localparam int STEP_W = $clog2(3*DIM-1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3*DIM-3);

  feeder_state_t     state_reg, state_next;
  logic [STEP_W-1:0] step_reg, step_next;
  logic              feed_next;
  logic              wr_ok;
  logic [DIM-1:0]    a_mask [DIM];
  logic [DIM-1:0]    b_mask;

  assign wr_ok     = wr_en_i && (state_reg == IDLE);
  assign feed_next = (state_next == FEED);

  // Ack has priority over go in HOLD simply because go is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    case (state_reg)
      IDLE: if (go_i) begin
        state_next = FEED;
        step_next  = '0;
      end
      FEED: if (step_reg == LAST_STEP) state_next = HOLD;
            else step_next = step_reg + 1'b1;
      HOLD: if (res_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      step_reg        <= '0;
      start_bit_o     <= 1'b0;
      busy_o          <= 1'b0;
      results_valid_o <= 1'b0;
    end else begin
      state_reg       <= state_next;
      step_reg        <= step_next;
      start_bit_o     <= (state_next != IDLE);
      busy_o          <= (state_next != IDLE);
      results_valid_o <= (state_next == HOLD);
    end
  end

  // A lanes own whole rows; B lanes own columns, so a B row write touches one element per lane.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      assign a_mask[gi] = (wr_ok && !wr_sel_i && wr_row_i == ROW_W'(gi)) ? '1 : '0;
      assign b_mask[gi] = wr_ok && wr_sel_i && (wr_row_i == ROW_W'(gi));

      feeder_lane #(
        .DATA_WIDTH(DATA_WIDTH), .DIM(DIM), .STEP_W(STEP_W), .LANE(gi)
      ) u_a_lane (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .wr_mask   (a_mask[gi]),
        .wr_vec    (wr_data_i),
        .feed_next (feed_next),
        .step_next (step_next),
        .lane_out  (a_row_o[gi*DATA_WIDTH +: DATA_WIDTH])
      );

      feeder_lane #(
        .DATA_WIDTH(DATA_WIDTH), .DIM(DIM), .STEP_W(STEP_W), .LANE(gi)
      ) u_b_lane (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .wr_mask   (b_mask),
        .wr_vec    ({DIM{wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH]}}),
        .feed_next (feed_next),
        .step_next (step_next),
        .lane_out  (b_col_o[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboarded bench: DIM=2/8-bit feeder with stream checks, plus DIM=4/16-bit scaling run.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DIM=2, DATA_WIDTH=8
  logic        d2_wr_en = 0, d2_wr_sel = 0, d2_wr_row = 0, d2_go = 0, d2_ack = 0;
  logic [15:0] d2_wr_data = '0;
  logic [15:0] d2_a, d2_b;
  logic        d2_start, d2_busy, d2_valid;

  // DIM=4, DATA_WIDTH=16
  logic        d4_wr_en = 0, d4_wr_sel = 0, d4_go = 0, d4_ack = 0;
  logic [1:0]  d4_wr_row = '0;
  logic [63:0] d4_wr_data = '0;
  logic [63:0] d4_a, d4_b;
  logic        d4_start, d4_busy, d4_valid;

  systolic_feeder #(.DATA_WIDTH(8), .DIM(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(d2_wr_en), .wr_sel_i(d2_wr_sel),
    .wr_row_i(d2_wr_row), .wr_data_i(d2_wr_data), .go_i(d2_go), .res_ack_i(d2_ack),
    .a_row_o(d2_a), .b_col_o(d2_b), .start_bit_o(d2_start), .busy_o(d2_busy),
    .results_valid_o(d2_valid)
  );

  systolic_feeder #(.DATA_WIDTH(16), .DIM(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(d4_wr_en), .wr_sel_i(d4_wr_sel),
    .wr_row_i(d4_wr_row), .wr_data_i(d4_wr_data), .go_i(d4_go), .res_ack_i(d4_ack),
    .a_row_o(d4_a), .b_col_o(d4_b), .start_bit_o(d4_start), .busy_o(d4_busy),
    .results_valid_o(d4_valid)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d want %0d", name, act, exp);
    else begin
      pass_cnt++;
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Behavioural output-stationary PE grids attached to each feeder.
  int g2_a [2][2], g2_b [2][2], g2_c [2][2];
  int g4_a [4][4], g4_b [4][4], g4_c [4][4];

  always @(posedge clk) begin
    int ai, bi;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (j == 0) ai = int'($signed(d2_a[i*8 +: 8])); else ai = g2_a[i][j-1];
        if (i == 0) bi = int'($signed(d2_b[j*8 +: 8])); else bi = g2_b[i-1][j];
        if (!d2_start) begin
          g2_a[i][j] <= 0; g2_b[i][j] <= 0; g2_c[i][j] <= 0;
        end else begin
          g2_a[i][j] <= ai; g2_b[i][j] <= bi; g2_c[i][j] <= g2_c[i][j] + ai * bi;
        end
      end
    end
  end

  always @(posedge clk) begin
    int ai, bi;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) ai = int'($signed(d4_a[i*16 +: 16])); else ai = g4_a[i][j-1];
        if (i == 0) bi = int'($signed(d4_b[j*16 +: 16])); else bi = g4_b[i-1][j];
        if (!d4_start) begin
          g4_a[i][j] <= 0; g4_b[i][j] <= 0; g4_c[i][j] <= 0;
        end else begin
          g4_a[i][j] <= ai; g4_b[i][j] <= bi; g4_c[i][j] <= g4_c[i][j] + ai * bi;
        end
      end
    end
  end

  // Scoreboard for the DIM=2 stream: one entry per expected FEED cycle.
  typedef struct packed { logic [15:0] a; logic [15:0] b; } lanes_t;
  lanes_t exp_q[$];

  task automatic push(input int a0, a1, b0, b1);
    lanes_t e;
    e.a = {8'(a1), 8'(a0)};
    e.b = {8'(b1), 8'(b0)};
    exp_q.push_back(e);
  endtask

  task automatic push_std();
    push(1, 0, 5, 0); push(2, 3, 7, 6); push(0, 4, 0, 8); push(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    lanes_t e;
    if (rst_n && d2_busy && !d2_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL stream_extra: got FEED cycle a=%h b=%h want none", d2_a, d2_b);
      end else begin
        e = exp_q.pop_front();
        check("feed_a_row", d2_a, e.a);
        check("feed_b_col", d2_b, e.b);
        check("feed_start", d2_start, 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr2(input logic sel, input logic row, input int e0, input int e1);
    d2_wr_en = 1; d2_wr_sel = sel; d2_wr_row = row; d2_wr_data = {8'(e1), 8'(e0)};
    tick();
    d2_wr_en = 0;
  endtask

  task automatic load_std();
    wr2(0, 0, 1, 2); wr2(0, 1, 3, 4); wr2(1, 0, 5, 6); wr2(1, 1, 7, 8);
  endtask

  task automatic go2();
    d2_go = 1; tick(); d2_go = 0;
  endtask

  task automatic wait_hold2();
    for (int n = 0; n < 40 && !d2_valid; n++) tick();
    check("hold_reached", d2_valid, 1);
    check("stream_drained", exp_q.size(), 0);
  endtask

  task automatic check_c2(input string tag, input int c00, c01, c10, c11);
    check({tag, "_c00"}, g2_c[0][0], c00);
    check({tag, "_c01"}, g2_c[0][1], c01);
    check({tag, "_c10"}, g2_c[1][0], c10);
    check({tag, "_c11"}, g2_c[1][1], c11);
  endtask

  task automatic ack2();
    d2_ack = 1; tick(); d2_ack = 0;
  endtask

  logic signed [15:0] bm [4][4];
  int feed_cycles;

  initial begin
    #12;
    check("rst_a_row", d2_a, 0);
    check("rst_b_col", d2_b, 0);
    check("rst_flags", {d2_start, d2_busy, d2_valid, d4_start, d4_busy, d4_valid}, 0);
    @(negedge clk); rst_n = 1;
    tick();

    // Stream check
    load_std(); push_std(); go2();
    wait_hold2();
    check_c2("run1", 19, 22, 43, 50);
    check("run1_start_hold", d2_start, 1);

    // Freeze for 10 cycles, then release
    repeat (10) tick();
    check("freeze_valid", d2_valid, 1);
    check_c2("freeze", 19, 22, 43, 50);
    ack2();
    check("ack_busy", d2_busy, 0);
    check("ack_start", d2_start, 0);
    check("ack_valid", d2_valid, 0);
    tick();
    check_c2("ack_clear", 0, 0, 0, 0);

    // Write during FEED is ignored
    push_std(); go2();
    d2_wr_en = 1; d2_wr_sel = 0; d2_wr_row = 0; d2_wr_data = {8'd9, 8'd9};
    tick(); d2_wr_en = 0;
    wait_hold2();
    check_c2("wrfeed", 19, 22, 43, 50);
    ack2();

    // go during FEED is ignored; go with ack in HOLD: ack wins
    push_std(); go2();
    tick(); d2_go = 1; tick(); d2_go = 0;
    wait_hold2();
    check_c2("gofeed", 19, 22, 43, 50);
    d2_go = 1; d2_ack = 1; tick(); d2_go = 0; d2_ack = 0;
    check("goack_busy", d2_busy, 0);
    repeat (3) tick();
    check("goack_no_run", d2_busy, 0);

    // Write and go together: run uses the updated row
    push(9, 0, 5, 0); push(9, 3, 7, 6); push(0, 4, 0, 8); push(0, 0, 0, 0);
    d2_wr_en = 1; d2_wr_sel = 0; d2_wr_row = 0; d2_wr_data = {8'd9, 8'd9}; d2_go = 1;
    tick(); d2_wr_en = 0; d2_go = 0;
    wait_hold2();
    check_c2("wrgo", 108, 126, 43, 50);
    ack2();

    // Reset at step 1
    push(9, 0, 5, 0); go2();
    tick();
    rst_n = 0; #1;
    check("mrst_a_row", d2_a, 0);
    check("mrst_b_col", d2_b, 0);
    check("mrst_flags", {d2_start, d2_busy, d2_valid}, 0);
    tick(); rst_n = 1; tick();
    check("mrst_drained", exp_q.size(), 0);
    push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
    go2();
    wait_hold2();
    check_c2("cleared_buf", 0, 0, 0, 0);
    ack2();
    load_std(); push_std(); go2();
    wait_hold2();
    check_c2("after_rst", 19, 22, 43, 50);
    ack2();

    // Scaling: DIM=4, 16-bit, A = I, B random signed
    for (int r = 0; r < 4; r++) begin
      d4_wr_en = 1; d4_wr_sel = 0; d4_wr_row = 2'(r); d4_wr_data = '0;
      d4_wr_data[r*16 +: 16] = 16'd1;
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      d4_wr_sel = 1; d4_wr_row = 2'(r);
      for (int c = 0; c < 4; c++) begin
        bm[r][c] = 16'($urandom);
        d4_wr_data[c*16 +: 16] = bm[r][c];
      end
      tick();
    end
    d4_wr_en = 0;
    d4_go = 1; tick(); d4_go = 0;
    feed_cycles = 0;
    while (d4_busy && !d4_valid && feed_cycles < 40) begin
      if (!d4_start) check("d4_start_feed", d4_start, 1);
      feed_cycles++;
      tick();
    end
    check("d4_feed_len", feed_cycles, 10);
    check("d4_valid", d4_valid, 1);
    tick();
    check("d4_start_hold", d4_start, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("d4_c%0d%0d", i, j), g4_c[i][j], int'(bm[i][j]));
    d4_ack = 1; tick(); d4_ack = 0;
    check("d4_ack_start", d4_start, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
